i2c_slave_regfile: RTL and testbench

Clock-domain I2C slave, the successor to the SCL-clocked slave. SCL/SDA are oversampled on the system clock and glitch-filtered. The block exposes a register map over I2C: NUM_REGS writable registers, followed by NUM_MEAS read-only measurement bytes. It supports a register pointer with auto-increment and wrap, multi-byte burst reads and writes, and repeated START. It sits between the pad-level open-drain I2C pins and the tag's configuration/measurement logic.

---
 rtl/i2c_slave_regfile.sv | 261 ++++++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C slave register file, clocked from the system clock.
// SCL/SDA are synchronised and glitch-filtered. The slave then exposes
// NUM_REGS writable bytes followed by NUM_MEAS read-only measurement bytes
// behind an auto-incrementing, wrapping register pointer.
//
// Ports:
//   clk        system clock (at least 16x SCL)
//   reset      asynchronous active-high reset
//   en         slave enable, sampled at START
//   my_addr    7-bit slave address
//   meas_in    read-only bytes, byte k at [8k+7:8k] -> pointer NUM_REGS+k
//   scl_in     SCL pad input (asynchronous)
//   sda_in     SDA pad input (asynchronous)
//   sda_oe     1 = pull SDA low, 0 = release
//   reg_bus    writable register contents, register k at [8k+7:8k]
//   wr_strobe  one-cycle pulse when a register is written
//   wr_index   index of the written register, valid with wr_strobe
//   busy       high from address ACK until STOP/START/return to IDLE
module i2c_slave_regfile #(
    parameter int NUM_REGS   = 4,
    parameter int NUM_MEAS   = 2,
    parameter int FILTER_LEN = 3,
    parameter int PTR_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [6:0]            my_addr,
    input  logic [8*NUM_MEAS-1:0] meas_in,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [8*NUM_REGS-1:0] reg_bus,
    output logic                  wr_strobe,
    output logic [PTR_W-1:0]      wr_index,
    output logic                  busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_t;

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [8:0] TOTAL9 = 9'(NUM_REGS + NUM_MEAS);
    localparam logic [8:0] REGS9 = 9'(NUM_REGS);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REGS + NUM_MEAS - 1);

    // Index 0 is SCL, index 1 is SDA throughout the input path.
    logic [1:0] sync1, sync2, filt, filt_prev;
    logic [CW-1:0] cnt [2];

    state_t state, state_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift_q, shift_n, tx_q, tx_n, rd_byte;
    logic is_read, is_read_n;
    logic [PTR_W-1:0] ptr, ptr_n, ptr_inc, wr_index_q, wr_index_n;
    logic [8*NUM_REGS-1:0] regs_q, regs_n;
    logic sda_oe_q, sda_oe_n, busy_q, busy_n, wr_strobe_q, wr_strobe_n;
    logic scl_f, sda_f, scl_rise, scl_fall, start_ev, stop_ev, byte_done;

    // Two-flop synchroniser followed by a counter filter: the filtered level
    // only follows the synchronised line after FILTER_LEN consecutive samples
    // that disagree with it, so short glitches never reach the event logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '1;
            sync2     <= '1;
            filt      <= '1;
            filt_prev <= '1;
            cnt[0]    <= '0;
            cnt[1]    <= '0;
        end else begin
            sync1     <= {sda_in, scl_in};
            sync2     <= sync1;
            filt_prev <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign scl_f     = filt[0];
    assign sda_f     = filt[1];
    assign scl_rise  = scl_f & ~filt_prev[0];
    assign scl_fall  = ~scl_f & filt_prev[0];
    // SCL must have been high in both samples so an SCL edge is never
    // mistaken for a START or STOP.
    assign start_ev  = filt_prev[1] & ~sda_f & scl_f & filt_prev[0];
    assign stop_ev   = ~filt_prev[1] & sda_f & scl_f & filt_prev[0];
    assign byte_done = scl_fall && (bit_cnt == 4'd8);
    assign ptr_inc   = (ptr == LAST_PTR) ? '0 : ptr + 1'b1;

    // Byte addressed by the pointer: a writable register or a measurement.
    always_comb begin
        rd_byte = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (9'(ptr) == 9'(k)) rd_byte = regs_q[8*k +: 8];
        for (int k = 0; k < NUM_MEAS; k++)
            if (9'(ptr) == 9'(NUM_REGS + k)) rd_byte = meas_in[8*k +: 8];
    end

    // State register and all datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            is_read     <= 1'b0;
            ptr         <= '0;
            regs_q      <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift_q     <= shift_n;
            tx_q        <= tx_n;
            is_read     <= is_read_n;
            ptr         <= ptr_n;
            regs_q      <= regs_n;
            sda_oe_q    <= sda_oe_n;
            busy_q      <= busy_n;
            wr_strobe_q <= wr_strobe_n;
            wr_index_q  <= wr_index_n;
        end
    end

    // Next-state logic. STOP and START override everything. Bits shift in on
    // SCL rise; all sda_oe changes are made on an SCL fall so that SDA only
    // moves while SCL is low. A write byte is committed only once all eight
    // bits are in, so an aborted byte never reaches the registers.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift_q;
        tx_n        = tx_q;
        is_read_n   = is_read;
        ptr_n       = ptr;
        regs_n      = regs_q;
        sda_oe_n    = sda_oe_q;
        busy_n      = busy_q;
        wr_strobe_n = 1'b0;
        wr_index_n  = wr_index_q;

        if (stop_ev) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else if (start_ev) begin
            state_n   = en ? ADDR : IDLE;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else begin
            if (scl_rise && bit_cnt < 4'd8 &&
                (state inside {ADDR, PTR, WR_DATA, RD_DATA})) begin
                shift_n   = {shift_q[6:0], sda_f};
                bit_cnt_n = bit_cnt + 4'd1;
            end
            case (state)
                ADDR: if (byte_done) begin
                    bit_cnt_n = '0;
                    if (shift_q[7:1] == my_addr) begin
                        state_n   = ADDR_ACK;
                        sda_oe_n  = 1'b1;
                        busy_n    = 1'b1;
                        is_read_n = shift_q[0];
                    end else begin
                        state_n  = IDLE;
                        sda_oe_n = 1'b0;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (is_read) begin
                        state_n  = RD_DATA;
                        sda_oe_n = ~rd_byte[7];
                        tx_n     = {rd_byte[6:0], 1'b0};
                    end else begin
                        state_n  = PTR;
                        sda_oe_n = 1'b0;
                    end
                end
                PTR: if (byte_done) begin
                    bit_cnt_n = '0;
                    if ({1'b0, shift_q} < TOTAL9) begin
                        ptr_n    = shift_q[PTR_W-1:0];
                        state_n  = PTR_ACK;
                        sda_oe_n = 1'b1;
                    end else begin
                        state_n  = IDLE;
                        sda_oe_n = 1'b0;
                        busy_n   = 1'b0;
                    end
                end
                PTR_ACK, WR_ACK: if (scl_fall) begin
                    state_n  = WR_DATA;
                    sda_oe_n = 1'b0;
                end
                WR_DATA: if (byte_done) begin
                    bit_cnt_n = '0;
                    state_n   = WR_ACK;
                    sda_oe_n  = 1'b1;
                    ptr_n     = ptr_inc;
                    // Measurement bytes are acknowledged but not stored.
                    if (9'(ptr) < REGS9) begin
                        for (int k = 0; k < NUM_REGS; k++)
                            if (9'(ptr) == 9'(k)) regs_n[8*k +: 8] = shift_q;
                        wr_strobe_n = 1'b1;
                        wr_index_n  = ptr;
                    end
                end
                RD_DATA: if (scl_fall) begin
                    if (bit_cnt == 4'd8) begin
                        state_n   = RD_ACK;
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                    end else begin
                        sda_oe_n = ~tx_q[7];
                        tx_n     = {tx_q[6:0], 1'b0};
                    end
                end
                // bit_cnt marks that the master's ACK bit has been sampled,
                // so the fall that entered RD_ACK cannot trigger a reload.
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_f) begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end else begin
                            ptr_n     = ptr_inc;
                            bit_cnt_n = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt != 4'd0) begin
                        state_n   = RD_DATA;
                        bit_cnt_n = '0;
                        sda_oe_n  = ~rd_byte[7];
                        tx_n      = {rd_byte[6:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe    = sda_oe_q;
    assign reg_bus   = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed testbench for i2c_slave_regfile: a bit-banged I2C master drives
// the pads and every observation is compared with a hand-computed value.
module tb_i2c_slave_regfile;

    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [6:0]  my_addr;
    logic [15:0] meas_in;
    logic        scl_pad;
    logic        sda_m;
    logic        sda_line;
    logic        sda_oe;
    logic [31:0] reg_bus;
    logic        wr_strobe;
    logic [7:0]  wr_index;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;
    int strobe_cnt = 0;
    int oe_cnt = 0;
    logic [7:0] last_idx = 8'h00;

    // Open-drain bus: the line is low if either side pulls it.
    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_regfile #(
        .NUM_REGS(4), .NUM_MEAS(2), .FILTER_LEN(3), .PTR_W(8)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .my_addr(my_addr),
        .meas_in(meas_in), .scl_in(scl_pad), .sda_in(sda_line),
        .sda_oe(sda_oe), .reg_bus(reg_bus), .wr_strobe(wr_strobe),
        .wr_index(wr_index), .busy(busy)
    );

    always #5 clk = ~clk;

    // Count write strobes and cycles with SDA pulled by the slave.
    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt = strobe_cnt + 1;
            last_idx = wr_index;
        end
        if (sda_oe) oe_cnt = oe_cnt + 1;
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic scl_v, input logic sda_v, input int n);
        scl_pad = scl_v;
        sda_m = sda_v;
        waitClk(n);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // With glitch set, a 1-clk SDA pulse lands in the high phase and a 1-clk
    // SCL pulse lands in the low phase.
    task automatic sendBit(input logic b, input bit glitch);
        applyStimulus(1'b0, b, Q);
        applyStimulus(1'b1, b, Q);
        if (glitch) begin
            applyStimulus(1'b1, ~b, 1);
            applyStimulus(1'b1, b, Q - 1);
            applyStimulus(1'b0, b, 3);
            applyStimulus(1'b1, b, 1);
            applyStimulus(1'b0, b, Q - 4);
        end else begin
            applyStimulus(1'b1, b, Q);
            applyStimulus(1'b0, b, Q);
        end
    endtask

    task automatic ackBit(output logic ack);
        applyStimulus(1'b0, 1'b1, Q);
        applyStimulus(1'b1, 1'b1, Q);
        ack = sda_oe;
        applyStimulus(1'b1, 1'b1, Q);
        applyStimulus(1'b0, 1'b1, Q);
    endtask

    task automatic writeByte(input logic [7:0] d, input bit glitch, output logic ack);
        for (int i = 7; i >= 0; i--) sendBit(d[i], glitch);
        ackBit(ack);
    endtask

    task automatic readByte(output logic [7:0] d, input logic mack);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b1, Q);
            applyStimulus(1'b1, 1'b1, Q);
            d[i] = sda_line;
            applyStimulus(1'b1, 1'b1, Q);
            applyStimulus(1'b0, 1'b1, Q);
        end
        sendBit(mack, 1'b0);
    endtask

    task automatic i2cStart();
        applyStimulus(scl_pad, 1'b1, Q);
        applyStimulus(1'b1, 1'b1, Q);
        applyStimulus(1'b1, 1'b0, Q);
        applyStimulus(1'b0, 1'b0, Q);
    endtask

    task automatic i2cStop();
        applyStimulus(1'b0, 1'b0, Q);
        applyStimulus(1'b1, 1'b0, Q);
        applyStimulus(1'b1, 1'b1, 2 * Q);
    endtask

    initial begin
        logic a, a1, a2, a3;
        logic [7:0] d1, d2;
        int s0, o0;

        reset = 1'b1;
        en = 1'b1;
        my_addr = 7'h42;
        meas_in = 16'h0000;
        scl_pad = 1'b1;
        sda_m = 1'b1;
        waitClk(4);
        checkOutput("reset_sda_oe", 32'(sda_oe), 32'h0);
        checkOutput("reset_reg_bus", reg_bus, 32'h0);
        checkOutput("reset_wr_strobe", 32'(wr_strobe), 32'h0);
        checkOutput("reset_wr_index", 32'(wr_index), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        waitClk(10);

        // Preload reg2 = 0x3C so the pointer can be observed through reads.
        i2cStart();
        writeByte(8'h84, 1'b0, a);
        writeByte(8'h02, 1'b0, a);
        writeByte(8'h3C, 1'b0, a);
        i2cStop();
        checkOutput("preload_reg_bus", reg_bus, 32'h003C0000);

        // Single write: ptr 1, data 0xA5.
        s0 = strobe_cnt;
        i2cStart();
        writeByte(8'h84, 1'b0, a1);
        checkOutput("t1_busy_after_ack", 32'(busy), 32'h1);
        writeByte(8'h01, 1'b0, a2);
        writeByte(8'hA5, 1'b0, a3);
        i2cStop();
        checkOutput("t1_addr_ack", 32'(a1), 32'h1);
        checkOutput("t1_ptr_ack", 32'(a2), 32'h1);
        checkOutput("t1_data_ack", 32'(a3), 32'h1);
        checkOutput("t1_reg_bus", reg_bus, 32'h003CA500);
        checkOutput("t1_strobes", 32'(strobe_cnt - s0), 32'h1);
        checkOutput("t1_wr_index", 32'(last_idx), 32'h1);
        checkOutput("t1_busy_after_stop", 32'(busy), 32'h0);
        // Pointer now 2: reading returns reg2.
        i2cStart();
        writeByte(8'h85, 1'b0, a);
        readByte(d1, 1'b1);
        i2cStop();
        checkOutput("t1_read_ptr2", 32'(d1), 32'h3C);

        // Burst write from ptr 3 across the measurement bytes, wrapping to 0.
        s0 = strobe_cnt;
        i2cStart();
        writeByte(8'h84, 1'b0, a);
        writeByte(8'h03, 1'b0, a);
        writeByte(8'h11, 1'b0, a1);
        writeByte(8'h22, 1'b0, a2);
        writeByte(8'h33, 1'b0, a3);
        i2cStop();
        checkOutput("t2_ack1", 32'(a1), 32'h1);
        checkOutput("t2_ack2", 32'(a2), 32'h1);
        checkOutput("t2_ack3", 32'(a3), 32'h1);
        checkOutput("t2_reg_bus", reg_bus, 32'h113CA500);
        checkOutput("t2_strobes", 32'(strobe_cnt - s0), 32'h1);
        checkOutput("t2_wr_index", 32'(last_idx), 32'h3);
        i2cStart();
        writeByte(8'h85, 1'b0, a);
        readByte(d1, 1'b0);
        readByte(d2, 1'b1);
        i2cStop();
        checkOutput("t2_read_ptr0", 32'(d1), 32'h00);
        checkOutput("t2_read_ptr1", 32'(d2), 32'hA5);

        // Pointer write, repeated START, measurement read.
        meas_in = 16'hBEEF;
        i2cStart();
        writeByte(8'h84, 1'b0, a);
        writeByte(8'h04, 1'b0, a1);
        i2cStart();
        writeByte(8'h85, 1'b0, a2);
        meas_in = 16'hBE00;
        readByte(d1, 1'b0);
        readByte(d2, 1'b1);
        checkOutput("t3_busy_after_nack", 32'(busy), 32'h0);
        i2cStop();
        checkOutput("t3_ptr_ack", 32'(a1), 32'h1);
        checkOutput("t3_rd_addr_ack", 32'(a2), 32'h1);
        checkOutput("t3_byte0", 32'(d1), 32'hEF);
        checkOutput("t3_byte1", 32'(d2), 32'hBE);

        // Wrong address, then right address with the slave disabled.
        o0 = oe_cnt;
        i2cStart();
        writeByte(8'h86, 1'b0, a1);
        i2cStop();
        checkOutput("t4_wrong_addr_ack", 32'(a1), 32'h0);
        checkOutput("t4_wrong_addr_oe", 32'(oe_cnt - o0), 32'h0);
        checkOutput("t4_wrong_addr_busy", 32'(busy), 32'h0);
        en = 1'b0;
        o0 = oe_cnt;
        i2cStart();
        writeByte(8'h84, 1'b0, a2);
        writeByte(8'h00, 1'b0, a);
        writeByte(8'h77, 1'b0, a);
        i2cStop();
        en = 1'b1;
        checkOutput("t4_disabled_ack", 32'(a2), 32'h0);
        checkOutput("t4_disabled_oe", 32'(oe_cnt - o0), 32'h0);
        checkOutput("t4_reg_bus", reg_bus, 32'h113CA500);

        // Out-of-range pointer: NACK, later data ignored, pointer kept at 5.
        s0 = strobe_cnt;
        i2cStart();
        writeByte(8'h84, 1'b0, a);
        writeByte(8'h07, 1'b0, a1);
        writeByte(8'h99, 1'b0, a2);
        i2cStop();
        checkOutput("t5_ptr_nack", 32'(a1), 32'h0);
        checkOutput("t5_data_ignored", 32'(a2), 32'h0);
        checkOutput("t5_strobes", 32'(strobe_cnt - s0), 32'h0);
        checkOutput("t5_reg_bus", reg_bus, 32'h113CA500);
        i2cStart();
        writeByte(8'h85, 1'b0, a);
        readByte(d1, 1'b1);
        i2cStop();
        checkOutput("t5_read_ptr5", 32'(d1), 32'hBE);

        // Glitches on SCL and SDA during a data byte must be filtered.
        s0 = strobe_cnt;
        i2cStart();
        writeByte(8'h84, 1'b0, a);
        writeByte(8'h00, 1'b0, a);
        writeByte(8'h66, 1'b1, a1);
        i2cStop();
        checkOutput("t6_glitch_ack", 32'(a1), 32'h1);
        checkOutput("t6_glitch_reg_bus", reg_bus, 32'h113CA566);
        checkOutput("t6_glitch_strobes", 32'(strobe_cnt - s0), 32'h1);
        checkOutput("t6_glitch_index", 32'(last_idx), 32'h0);

        // STOP in the middle of a data byte: nothing committed.
        s0 = strobe_cnt;
        i2cStart();
        writeByte(8'h84, 1'b0, a);
        writeByte(8'h01, 1'b0, a);
        for (int i = 0; i < 4; i++) sendBit(1'b1, 1'b0);
        i2cStop();
        checkOutput("t6_abort_strobes", 32'(strobe_cnt - s0), 32'h0);
        checkOutput("t6_abort_reg_bus", reg_bus, 32'h113CA566);
        checkOutput("t6_abort_busy", 32'(busy), 32'h0);

        // Reset while the slave is driving the address ACK.
        i2cStart();
        for (int i = 7; i >= 0; i--) sendBit(logic'((8'h84 >> i) & 8'h01), 1'b0);
        applyStimulus(1'b0, 1'b1, Q);
        applyStimulus(1'b1, 1'b1, Q);
        checkOutput("t6_oe_before_reset", 32'(sda_oe), 32'h1);
        reset = 1'b1;
        waitClk(1);
        checkOutput("t6_oe_after_reset", 32'(sda_oe), 32'h0);
        checkOutput("t6_busy_after_reset", 32'(busy), 32'h0);
        checkOutput("t6_reg_bus_after_reset", reg_bus, 32'h0);
        checkOutput("t6_wr_index_after_reset", 32'(wr_index), 32'h0);
        waitClk(2);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 2 * Q);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
